// File: rtl/core.sv
// core: target-prediction protocol types shared by the execute stage, the
// feedback generator and the target predictor.
//   targ_resolve_t   : one resolved control transfer from an execute lane.
//   targ_pred_fb_t   : one update presented to the predictor's fb port.
//   targ_pred_fb_rst : idle/reset value of targ_pred_fb_t.
//   targ_resolve_rst : idle/reset value of targ_resolve_t.
package core;

    // Number of predictor tables; table_index must be able to name each one.
    localparam int TABLE_CNT = 2;
    localparam int TIDX_W    = (TABLE_CNT > 1) ? $clog2(TABLE_CNT) : 1;

    typedef logic [TIDX_W-1:0] tidx_t;

    typedef struct packed {
        logic       valid;
        tidx_t      table_index;
        sys::addr_t addr;
        sys::addr_t targ_addr;
        sys::addr_t pred_targ;
    } targ_resolve_t;

    typedef struct packed {
        logic       valid;
        tidx_t      table_index;
        sys::addr_t addr;
        sys::addr_t targ_addr;
        logic       mispred;
    } targ_pred_fb_t;

    localparam targ_pred_fb_t targ_pred_fb_rst = '0;
    localparam targ_resolve_t targ_resolve_rst = '0;

endpackage

// File: rtl/sys.sv
// sys: system-wide basic types shared by the core and its predictors.
//   addr_t : instruction/byte address type used by all branch structures.
package sys;

    typedef logic [31:0] addr_t;

endpackage

// File: rtl/targ_fb_gen_pkg.sv
// targ_fb_gen_pkg: internal queue-entry type and helpers for targ_fb_gen.
//   fb_entry_t     : one queued feedback record (fb fields minus valid).
//   is_mispred     : lane holds a valid result whose prediction was wrong.
//   entry_from_res : converts a resolved lane into a queue entry.
//   same_key       : two entries address the same predictor slot.
package targ_fb_gen_pkg;

    typedef struct packed {
        core::tidx_t table_index;
        sys::addr_t  addr;
        sys::addr_t  targ_addr;
        logic        mispred;
    } fb_entry_t;

    localparam fb_entry_t FB_ENTRY_RST = '0;

    function automatic logic is_mispred(input core::targ_resolve_t r);
        return r.valid && (r.pred_targ != r.targ_addr);
    endfunction

    function automatic fb_entry_t entry_from_res(input core::targ_resolve_t r);
        fb_entry_t e;
        e.table_index = r.table_index;
        e.addr        = r.addr;
        e.targ_addr   = r.targ_addr;
        e.mispred     = is_mispred(r);
        return e;
    endfunction

    function automatic logic same_key(input fb_entry_t a, input fb_entry_t b);
        return (a.table_index == b.table_index) && (a.addr == b.addr);
    endfunction

endpackage

// File: rtl/targ_fb_fifo.sv
// targ_fb_fifo: multi-push, single-pop queue of feedback entries.
// Up to PUSH_W compacted entries (push_data[0..push_cnt-1]) are written per
// cycle in order; one entry is popped per cycle from the head.
// Pointers carry one extra wrap bit: empty = pointers equal,
// full = wrap bits differ and index bits equal.
// Ports:
//   clk, rst       : clock, synchronous active-high reset (clears storage too)
//   clr            : drop all entries (pointers to 0), no push/pop this cycle
//   push_cnt       : number of valid leading entries in push_data
//   push_data      : compacted entries to append
//   pop            : remove head entry (ignored when empty)
//   tail_wr*       : with TARG_FB_COALESCE_EN, rewrite the newest entry
//   tail_o         : with TARG_FB_COALESCE_EN, newest stored entry
//   head_o         : oldest stored entry
//   empty_o/full_o : queue state
//   occ_o          : number of stored entries
module targ_fb_fifo
    import targ_fb_gen_pkg::*;
#(
    parameter int PUSH_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [$clog2(DEPTH):0]   push_cnt,
    input  fb_entry_t                push_data [PUSH_W],
    input  logic                     pop,
`ifdef TARG_FB_COALESCE_EN
    input  logic                     tail_wr,
    input  fb_entry_t                tail_wr_data,
    output fb_entry_t                tail_o,
`endif
    output fb_entry_t                head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   occ_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    fb_entry_t     mem_q [DEPTH];
    fb_entry_t     mem_d [DEPTH];
    logic [AW-1:0] wr_idx_s;

    // Storage and pointer next-state: appends, optional tail rewrite, pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wr_idx_s = '0;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
`ifdef TARG_FB_COALESCE_EN
            if (tail_wr) begin
                mem_d[wr_ptr_q[AW-1:0] - AW'(1)] = tail_wr_data;
            end else begin
                mem_d[wr_ptr_q[AW-1:0] - AW'(1)] = mem_q[wr_ptr_q[AW-1:0] - AW'(1)];
            end
`endif
            for (int k = 0; k < PUSH_W; k++) begin
                wr_idx_s = wr_ptr_q[AW-1:0] + AW'(k);
                if (CW'(k) < push_cnt) begin
                    mem_d[wr_idx_s] = push_data[k];
                end else begin
                    mem_d[wr_idx_s] = mem_d[wr_idx_s];
                end
            end
            wr_ptr_d = wr_ptr_q + push_cnt;
            if (pop && !empty_o) begin
                rd_ptr_d = rd_ptr_q + CW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Queue state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: FB_ENTRY_RST};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    // Status and head/tail views derived from the pointers.
    always_comb begin
        empty_o = (wr_ptr_q == rd_ptr_q);
        full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        occ_o   = wr_ptr_q - rd_ptr_q;
        head_o  = mem_q[rd_ptr_q[AW-1:0]];
`ifdef TARG_FB_COALESCE_EN
        tail_o  = mem_q[wr_ptr_q[AW-1:0] - AW'(1)];
`endif
    end

endmodule

// File: rtl/targ_fb_gen.sv
// targ_fb_gen: branch-resolution feedback generator for the target predictor.
// Filters up to s_pipe_cnt resolved results per cycle, queues them in lane
// order and drains one update per cycle to the predictor fb port.
// Optional build macro: TARG_FB_COALESCE_EN -- a result whose
// {table_index, addr} matches the newest queued entry rewrites that entry
// instead of allocating a new one.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   flush     : discard all queued feedback; res ignored that cycle
//   res       : per-lane resolved control transfers
//   fb_rdy    : predictor accepts fb this cycle
//   fb        : head feedback; fb.valid = queue non-empty
//   stall     : registered, free entries < s_pipe_cnt after this edge
//   drop_cnt  : saturating count of results lost to overflow
module targ_fb_gen
    import targ_fb_gen_pkg::*;
#(
    parameter int s_pipe_cnt = 3,
    parameter int table_cnt  = 2,
    parameter int fifo_depth = 8,
    parameter int fb_on_hit  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  core::targ_resolve_t res [s_pipe_cnt],
    input  logic                fb_rdy,
    output core::targ_pred_fb_t fb,
    output logic                stall,
    output logic [15:0]         drop_cnt
);
    localparam int AW  = $clog2(fifo_depth);
    localparam int CW  = AW + 1;
    localparam int SIW = (s_pipe_cnt > 1) ? $clog2(s_pipe_cnt) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(fifo_depth);
    localparam logic [CW-1:0] LANES_C = CW'(s_pipe_cnt);

    if ((fifo_depth < s_pipe_cnt) || ((fifo_depth & (fifo_depth - 1)) != 0)) begin : g_bad_depth
        $error("targ_fb_gen: fifo_depth must be a power of two and >= s_pipe_cnt");
    end
    if (table_cnt > (1 << core::TIDX_W)) begin : g_bad_tables
        $error("targ_fb_gen: table_cnt does not fit core::tidx_t");
    end

    logic          clr_s;
    logic          pop_s;
    logic          empty_s;
    logic          full_s;
    logic [CW-1:0] occ_s;
    logic [CW-1:0] free_s;
    logic [CW-1:0] push_cnt_s;
    logic [CW-1:0] drop_n_s;
    logic [CW-1:0] occ_nxt_s;
    logic [16:0]   drop_sum_s;
    fb_entry_t     head_s;
    fb_entry_t     slot_s [s_pipe_cnt];
    logic          stall_q, stall_d;
    logic [15:0]   drop_cnt_q, drop_cnt_d;
`ifdef TARG_FB_COALESCE_EN
    fb_entry_t     tail_s;
    fb_entry_t     tail_wr_data_s;
    logic          tail_wr_s;
    logic          tail_live_s;
    logic          slot_live_s;
    logic [SIW-1:0] newest_slot_s;
`endif

    // Clear/pop decision and free space; a same-cycle pop frees one slot.
    always_comb begin
        clr_s = rst || flush;
        pop_s = !empty_s && fb_rdy && !clr_s;
        if (full_s) begin
            free_s = '0;
        end else begin
            free_s = DEPTH_C - occ_s;
        end
        free_s = free_s + CW'(pop_s);
    end

    // Lane filter: eligible lanes are compacted in ascending order; those
    // beyond the free space are dropped, so the highest lanes lose first.
    always_comb begin
        slot_s     = '{default: FB_ENTRY_RST};
        push_cnt_s = '0;
        drop_n_s   = '0;
`ifdef TARG_FB_COALESCE_EN
        tail_wr_s      = 1'b0;
        tail_wr_data_s = tail_s;
        slot_live_s    = 1'b0;
        newest_slot_s  = '0;
        // The stored tail may be rewritten unless it is the head leaving now.
        tail_live_s    = (occ_s != '0) && !((occ_s == CW'(1)) && pop_s);
`endif
        for (int i = 0; i < s_pipe_cnt; i++) begin
            if (!clr_s && res[i].valid && (is_mispred(res[i]) || (fb_on_hit != 0))) begin
`ifdef TARG_FB_COALESCE_EN
                // Newest entry is the last slot written this cycle, else the stored tail.
                if (slot_live_s && same_key(slot_s[newest_slot_s], entry_from_res(res[i]))) begin
                    slot_s[newest_slot_s].targ_addr = res[i].targ_addr;
                    slot_s[newest_slot_s].mispred   = is_mispred(res[i]);
                end else if (!slot_live_s && tail_live_s &&
                             same_key(tail_wr_data_s, entry_from_res(res[i]))) begin
                    tail_wr_s                = 1'b1;
                    tail_wr_data_s.targ_addr = res[i].targ_addr;
                    tail_wr_data_s.mispred   = is_mispred(res[i]);
                end else
`endif
                if (push_cnt_s < free_s) begin
                    slot_s[SIW'(push_cnt_s)] = entry_from_res(res[i]);
`ifdef TARG_FB_COALESCE_EN
                    newest_slot_s = SIW'(push_cnt_s);
                    slot_live_s   = 1'b1;
`endif
                    push_cnt_s = push_cnt_s + CW'(1);
                end else begin
                    drop_n_s = drop_n_s + CW'(1);
                end
            end else begin
                drop_n_s = drop_n_s;
            end
        end
    end

    // Post-edge occupancy drives stall; drop counter saturates at 0xFFFF.
    always_comb begin
        if (clr_s) begin
            occ_nxt_s = '0;
        end else begin
            occ_nxt_s = occ_s + push_cnt_s - CW'(pop_s);
        end
        stall_d    = (DEPTH_C - occ_nxt_s) < LANES_C;
        drop_sum_s = 17'(drop_cnt_q) + 17'(drop_n_s);
        if (drop_sum_s[16]) begin
            drop_cnt_d = 16'hFFFF;
        end else begin
            drop_cnt_d = drop_sum_s[15:0];
        end
    end

    // Stall and drop counter registers; flush leaves the drop count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q    <= 1'b0;
            drop_cnt_q <= 16'h0000;
        end else begin
            stall_q    <= stall_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    targ_fb_fifo #(
        .PUSH_W (s_pipe_cnt),
        .DEPTH  (fifo_depth)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr_s),
        .push_cnt     (push_cnt_s),
        .push_data    (slot_s),
        .pop          (pop_s),
`ifdef TARG_FB_COALESCE_EN
        .tail_wr      (tail_wr_s),
        .tail_wr_data (tail_wr_data_s),
        .tail_o       (tail_s),
`endif
        .head_o       (head_s),
        .empty_o      (empty_s),
        .full_o       (full_s),
        .occ_o        (occ_s)
    );

    // Feedback comes straight from the head entry registers.
    always_comb begin
        fb             = core::targ_pred_fb_rst;
        fb.valid       = !empty_s;
        fb.table_index = head_s.table_index;
        fb.addr        = head_s.addr;
        fb.targ_addr   = head_s.targ_addr;
        fb.mispred     = head_s.mispred;
    end

    assign stall    = stall_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: doc/targ_fb_gen.md
# targ_fb_gen

Branch-resolution side of the target-prediction protocol. Each cycle it collects up to `s_pipe_cnt` resolved control-transfer results from the execute stage, filters them, and queues them in a small FIFO. It drains that FIFO as one `core::targ_pred_fb_t` update per cycle into the target predictor's `fb` port. It sits between the execute/branch-resolve lanes and the predictor, and back-pressures the front end through `stall` when its queue cannot absorb a full cycle of results.

## Interface
- `s_pipe_cnt`, 3: resolve lanes per cycle; same value as the predictor.
- `table_cnt`, 2: number of predictor tables; sets the width of `table_index`.
- `fifo_depth`, 8: queue entries; power of two, ≥ `s_pipe_cnt`.
- `fb_on_hit`, 0: 1 = also enqueue correctly predicted branches; 0 = enqueue mispredicts only.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `flush`  in  1: discard all queued feedback.
- `res`  in  `core::targ_resolve_t [s_pipe_cnt]`: per-lane `{valid, table_index, addr, targ_addr, pred_targ}`.
- `fb_rdy`  in  1: predictor accepts `fb` this cycle (predictor `en`).
- `fb`  out  `core::targ_pred_fb_t`: `{valid, table_index, addr, targ_addr, mispred}`.
- `stall`  out  1: free entries < `s_pipe_cnt`.
- `drop_cnt`  out  16: saturating count of results lost to overflow.

## Operation
- Mispredict for a lane = `res[i].valid && (res[i].pred_targ != res[i].targ_addr)`.
- A lane is eligible when it is a mispredict, or when `res[i].valid && fb_on_hit`.
- Eligible lanes are enqueued in ascending lane order in one cycle, and `mispred` is stored with each entry.
- `fb` is driven combinationally from the head entry's registers. `fb.valid` = queue non-empty.
- Pop happens when `fb.valid && fb_rdy`.
- Push and pop in the same cycle are allowed. Occupancy next = occ + pushed − popped.
- Overflow: eligible lanes beyond the free space count (after the same-cycle pop is credited) are dropped, highest lane first.
  - `drop_cnt` increases by the number dropped and saturates at 0xFFFF.
  - Lower lanes are still enqueued.
- `stall` is registered and reflects occupancy after the current edge: 1 when `fifo_depth − occ < s_pipe_cnt`.
- `flush` has priority over push and pop:
  - occupancy goes to 0; `res` inputs that cycle are ignored.
  - `fb.valid` is 0 the next cycle, and nothing is popped on the flush cycle regardless of `fb_rdy`.
  - `drop_cnt` is unchanged.
- Read and write pointers are `$clog2(fifo_depth)`+1 bits; wrap is natural modulo.
  - Full = MSBs differ and low bits are equal.
  - Empty = pointers equal.

## Timing
- Reset values: `fb.valid`=0, all `fb` fields 0 (`core::targ_pred_fb_rst`), `stall`=0, `drop_cnt`=0, pointers 0.
- Latency: a result presented at edge N is visible on `fb` in cycle N+1 if the queue was empty. There is no same-cycle bypass.
- Throughput: 1 feedback per cycle.
- `rst` mid-operation behaves identically to `flush` and also clears `drop_cnt`.
- `fb` is stable while `fb.valid && !fb_rdy`.

## Configuration
- `TARG_FB_COALESCE_EN` defined:
  - An eligible result whose `{table_index, addr}` equals the newest queued entry (the tail, or an earlier lane written in the same cycle) overwrites that entry's `targ_addr` and `mispred` and allocates nothing.
  - The tail is not coalesced if it is the head being popped this cycle.
- Undefined: every eligible result allocates its own entry.

## Structure
- `core` package holds:
  - `targ_resolve_t`
  - `targ_pred_fb_t`
  - `targ_pred_fb_rst`
  - `targ_resolve_rst`
- Address type is `sys::addr_t`.
- One sub-module, `targ_fb_fifo`: a multi-push (`s_pipe_cnt`), single-pop queue with occupancy output. Filtering, coalescing, drop counting and `stall` live in `targ_fb_gen`.

## Test plan
- Reset, then idle → `fb.valid`=0, `stall`=0, `drop_cnt`=0.
- Lane 1 resolves addr 0x100, targ 0x200, pred 0x180, `fb_rdy`=1 → next cycle `fb`={1, tbl, 0x100, 0x200, mispred=1}; empty the cycle after.
- All 3 lanes mispredict at distinct addrs, `fb_rdy`=1 → three consecutive `fb` in lane order 0,1,2.
- `fb_on_hit`=0, correct prediction (pred==targ) → nothing enqueued; with `fb_on_hit`=1 → one entry with `mispred`=0.
- `fb_rdy`=0, 3 mispredicts per cycle, depth 8 → `stall`=1 once occ ≥ 6; third cycle enqueues 2 and `drop_cnt`=1; `fb` holds its head value.
- Queue holding 5 entries, `flush`=1 with `fb_rdy`=1 → next cycle `fb.valid`=0, occ 0. With `TARG_FB_COALESCE_EN`, two lanes at the same addr → one entry carrying the later lane's `targ_addr`.
